// File: rtl/combo_lock_pkg.sv
// rtl/combo_lock_pkg.sv - shared state encoding, button indices and width helper for the combination lock
//
// Purpose: common definitions imported by btn_edge and combo_lock_core.
//   state_t  : 3-bit lock state encoding
//   BTN_*    : bit positions of the buttons inside the 5-bit button vector
//   clog2()  : ceiling log2, usable in port and localparam widths

package combo_lock_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_CHECK   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_LOCKOUT = 3'd4,
    ST_PROGRAM = 3'd5
  } state_t;

  localparam int BTN_W = 5;
  localparam int BTN_C = 0;
  localparam int BTN_R = 1;
  localparam int BTN_L = 2;
  localparam int BTN_U = 3;
  localparam int BTN_D = 4;

  // Smallest w with 2**w >= n.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - parametrised-width rising-edge detector with synchronous reset
//
// Purpose: one-cycle pulse per rising level on each input bit.
// Ports:
//   clk     in  1 : clock
//   i_rst   in  1 : synchronous active-high reset
//   i_btn   in  W : raw button levels
//   o_rise  out W : i_btn & ~previous i_btn, forced low while in reset

module btn_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_btn,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_prev;

  // In reset the history is loaded with the live levels rather than zero:
  // with no button held this is the all-zero reset value, and a button that
  // is already held when reset releases does not count as a fresh press.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_prev <= i_btn;
    end else begin
      r_prev <= i_btn;
    end
  end

  assign o_rise = i_rst ? '0 : (i_btn & ~r_prev);

endmodule

// File: rtl/combo_lock_core.sv
// rtl/combo_lock_core.sv - combination lock engine with retry lockout and reprogrammable code
//
// Purpose: edge-detects the push buttons, steps a digit cursor, collects
// DIGITS committed digits and compares them with a stored code.
// Ports:
//   clk        in  1          : clock, rising edge
//   btnD       in  1          : synchronous active-high reset
//   btnU       in  1          : program / clear request (level)
//   btnL       in  1          : cursor decrement (level)
//   btnR       in  1          : cursor increment (level)
//   btnC       in  1          : commit cursor digit (level)
//   cur_val    out DIGIT_W    : cursor value
//   entry_bus  out CODE_W     : committed digits, newest in the LSBs
//   entry_cnt  out CNT_W      : number of committed digits
//   unlocked   out 1          : lock is open
//   prog_mode  out 1          : code programming in progress
//   lockout    out 1          : retry lockout active
//   tries      out TRY_W      : consecutive failed attempts

module combo_lock_core
  import combo_lock_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int DIGIT_W        = 4,
  parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'hFACE,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           btnD,
  input  logic                           btnU,
  input  logic                           btnL,
  input  logic                           btnR,
  input  logic                           btnC,
  output logic [DIGIT_W-1:0]             cur_val,
  output logic [DIGITS*DIGIT_W-1:0]      entry_bus,
  output logic [clog2(DIGITS+1)-1:0]     entry_cnt,
  output logic                           unlocked,
  output logic                           prog_mode,
  output logic                           lockout,
  output logic [clog2(MAX_TRIES+1)-1:0]  tries
);

  localparam int CODE_W = DIGITS * DIGIT_W;
  localparam int CNT_W  = clog2(DIGITS + 1);
  localparam int TRY_W  = clog2(MAX_TRIES + 1);
  localparam int TMR_W  = clog2(LOCKOUT_CYCLES + 1);

  state_t              r_state;
  logic [CODE_W-1:0]   r_code;
  logic [DIGIT_W-1:0]  r_cur;
  logic [CODE_W-1:0]   r_entry;
  logic [CNT_W-1:0]    r_cnt;
  logic [TRY_W-1:0]    r_tries;
  logic [TMR_W-1:0]    r_timer;

  state_t              w_state_nxt;
  logic [CODE_W-1:0]   w_code_nxt;
  logic [DIGIT_W-1:0]  w_cur_nxt;
  logic [CODE_W-1:0]   w_entry_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [TRY_W-1:0]    w_tries_nxt;
  logic [TMR_W-1:0]    w_timer_nxt;

  logic [BTN_W-1:0]    w_edge;
  logic                w_unused_rst_edge;
  logic                w_active;
  logic                w_do_c;
  logic                w_do_u;
  logic                w_do_move;
  logic [CODE_W-1:0]   w_shift;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_full;
  logic [TRY_W-1:0]    w_tries_inc;

  btn_edge #(.W(BTN_W)) u_btn_edge (
    .clk    (clk),
    .i_rst  (btnD),
    .i_btn  ({btnD, btnU, btnL, btnR, btnC}),
    .o_rise (w_edge)
  );

  // The reset button is edge-detected with the others but only its level matters.
  assign w_unused_rst_edge = w_edge[BTN_D];

  // Buttons only act in the interactive states; C beats U beats L/R.
  assign w_active  = (r_state == ST_ENTRY) || (r_state == ST_OPEN) || (r_state == ST_PROGRAM);
  assign w_do_c    = w_active && w_edge[BTN_C];
  assign w_do_u    = w_active && w_edge[BTN_U] && !w_edge[BTN_C];
  assign w_do_move = w_active && !w_edge[BTN_C] && !w_edge[BTN_U];

  // Shift expression stays legal for DIGITS == 1, where a slice would not.
  assign w_shift     = (r_entry << DIGIT_W) | CODE_W'(r_cur);
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_full      = (w_cnt_inc == CNT_W'(DIGITS));
  assign w_tries_inc = r_tries + TRY_W'(1);

  always_ff @(posedge clk) begin
    if (btnD) begin
      r_state <= ST_ENTRY;
      r_code  <= DEFAULT_CODE;
      r_cur   <= '0;
      r_entry <= '0;
      r_cnt   <= '0;
      r_tries <= '0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_cur   <= w_cur_nxt;
      r_entry <= w_entry_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tries <= w_tries_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_cur_nxt   = r_cur;
    w_entry_nxt = r_entry;
    w_cnt_nxt   = r_cnt;
    w_tries_nxt = r_tries;
    w_timer_nxt = r_timer;

    // L and R pressed together cancel.
    if (w_do_move) begin
      if (w_edge[BTN_R] && !w_edge[BTN_L]) begin
        w_cur_nxt = r_cur + DIGIT_W'(1);
      end else if (w_edge[BTN_L] && !w_edge[BTN_R]) begin
        w_cur_nxt = r_cur - DIGIT_W'(1);
      end
    end

    case (r_state)
      ST_ENTRY: begin
        if (w_do_c) begin
          w_entry_nxt = w_shift;
          w_cnt_nxt   = w_cnt_inc;
          if (w_full) w_state_nxt = ST_CHECK;
        end else if (w_do_u) begin
          w_entry_nxt = '0;
          w_cnt_nxt   = '0;
        end
      end
      ST_CHECK: begin
        w_entry_nxt = '0;
        w_cnt_nxt   = '0;
        if (r_entry == r_code) begin
          w_state_nxt = ST_OPEN;
          w_tries_nxt = '0;
        end else begin
          w_state_nxt = ST_FAIL;
        end
      end
      ST_FAIL: begin
        w_tries_nxt = w_tries_inc;
        if (w_tries_inc == TRY_W'(MAX_TRIES)) begin
          w_state_nxt = ST_LOCKOUT;
          w_timer_nxt = TMR_W'(LOCKOUT_CYCLES - 1);
        end else begin
          w_state_nxt = ST_ENTRY;
        end
      end
      ST_LOCKOUT: begin
        if (r_timer == '0) begin
          w_tries_nxt = '0;
          w_state_nxt = ST_ENTRY;
        end else begin
          w_timer_nxt = r_timer - TMR_W'(1);
        end
      end
      ST_OPEN: begin
        if (w_do_c) begin
          w_entry_nxt = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_ENTRY;
        end else if (w_do_u) begin
          w_state_nxt = ST_PROGRAM;
        end
      end
      ST_PROGRAM: begin
        if (w_do_c) begin
          if (w_full) begin
            // The digit committed this cycle is part of the new code.
            w_code_nxt  = w_shift;
            w_entry_nxt = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_ENTRY;
          end else begin
            w_entry_nxt = w_shift;
            w_cnt_nxt   = w_cnt_inc;
          end
        end else if (w_do_u) begin
          w_entry_nxt = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_OPEN;
        end
      end
      default: begin
        w_state_nxt = ST_ENTRY;
      end
    endcase
  end

  assign cur_val   = r_cur;
  assign entry_bus = r_entry;
  assign entry_cnt = r_cnt;
  assign tries     = r_tries;
  assign unlocked  = (r_state == ST_OPEN);
  assign prog_mode = (r_state == ST_PROGRAM);
  assign lockout   = (r_state == ST_LOCKOUT);

endmodule

// File: tb/tb_combo_lock_core.sv
// tb/tb_combo_lock_core.sv - self-checking bench for combo_lock_core against a digit-list model

module tb_combo_lock_core;

  localparam int DIGITS = 4;
  localparam int DW     = 4;
  localparam int MAXT   = 3;
  localparam int LC     = 16;
  localparam logic [15:0] DEF_CODE = 16'hFACE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic bD = 1'b1, bU = 1'b0, bL = 1'b0, bR = 1'b0, bC = 1'b0;
  logic [3:0]  cur_val;
  logic [15:0] entry_bus;
  logic [2:0]  entry_cnt;
  logic        unlocked, prog_mode, lockout;
  logic [1:0]  tries;

  combo_lock_core #(
    .DIGITS(DIGITS), .DIGIT_W(DW), .DEFAULT_CODE(DEF_CODE),
    .MAX_TRIES(MAXT), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk(clk), .btnD(bD), .btnU(bU), .btnL(bL), .btnR(bR), .btnC(bC),
    .cur_val(cur_val), .entry_bus(entry_bus), .entry_cnt(entry_cnt),
    .unlocked(unlocked), .prog_mode(prog_mode), .lockout(lockout), .tries(tries)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the lock as a mode name, a list of entered digits and a stored digit list.
  string m_mode;
  int    m_cur, m_tries, m_left;
  int    m_entry[$];
  int    m_code[DIGITS];
  bit    m_valid = 1'b0;
  bit [3:0] m_prev;

  function automatic logic [31:0] m_bus();
    logic [31:0] v;
    v = 0;
    foreach (m_entry[i]) v = (v << DW) | m_entry[i];
    return v;
  endfunction

  function automatic bit m_match();
    if (m_entry.size() != DIGITS) return 1'b0;
    for (int i = 0; i < DIGITS; i++) if (m_entry[i] != m_code[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit eu, el, er, ec;
    if (bD) begin
      m_mode = "ENTRY"; m_cur = 0; m_tries = 0; m_left = 0;
      m_entry.delete();
      for (int i = 0; i < DIGITS; i++) m_code[i] = int'((DEF_CODE >> (DW * (DIGITS - 1 - i))) & 16'hF);
      m_prev  = {bU, bL, bR, bC};
      m_valid = 1'b1;
      return;
    end
    eu = bU && !m_prev[3];
    el = bL && !m_prev[2];
    er = bR && !m_prev[1];
    ec = bC && !m_prev[0];
    m_prev = {bU, bL, bR, bC};
    if (m_mode == "CHECK") begin
      if (m_match()) begin m_mode = "OPEN"; m_tries = 0; end
      else m_mode = "FAIL";
      m_entry.delete();
    end else if (m_mode == "FAIL") begin
      m_tries++;
      if (m_tries == MAXT) begin m_mode = "LOCKOUT"; m_left = LC; end
      else m_mode = "ENTRY";
    end else if (m_mode == "LOCKOUT") begin
      m_left--;
      if (m_left == 0) begin m_tries = 0; m_mode = "ENTRY"; end
    end else if (ec) begin
      if (m_mode == "OPEN") begin
        m_entry.delete(); m_mode = "ENTRY";
      end else begin
        m_entry.push_back(m_cur);
        if (m_entry.size() == DIGITS) begin
          if (m_mode == "ENTRY") m_mode = "CHECK";
          else begin
            for (int i = 0; i < DIGITS; i++) m_code[i] = m_entry[i];
            m_entry.delete(); m_mode = "ENTRY";
          end
        end
      end
    end else if (eu) begin
      if (m_mode == "ENTRY") m_entry.delete();
      else if (m_mode == "OPEN") m_mode = "PROGRAM";
      else begin m_entry.delete(); m_mode = "OPEN"; end
    end else begin
      m_cur = (m_cur + int'(er) - int'(el) + 16) % 16;
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    if (m_valid) begin
      check("cur_val",   cur_val,   m_cur);
      check("entry_bus", entry_bus, m_bus());
      check("entry_cnt", entry_cnt, m_entry.size());
      check("unlocked",  unlocked,  m_mode == "OPEN");
      check("prog_mode", prog_mode, m_mode == "PROGRAM");
      check("lockout",   lockout,   m_mode == "LOCKOUT");
      check("tries",     tries,     m_tries);
    end
  end

  // 0=U 1=L 2=R 3=C 4=D
  task automatic set_btn(input int which, input logic v);
    case (which)
      0: bU = v;
      1: bL = v;
      2: bR = v;
      3: bC = v;
      default: bD = v;
    endcase
  endtask

  task automatic pulse(input int which);
    @(negedge clk); set_btn(which, 1'b1);
    @(negedge clk); set_btn(which, 1'b0);
  endtask

  task automatic dial(input int d);
    for (int i = 0; i < 20 && m_cur != d; i++) pulse(2);
  endtask

  task automatic enter(input logic [15:0] code, input int n);
    for (int i = 0; i < n; i++) begin
      dial(int'((code >> (DW * (DIGITS - 1 - i))) & 16'hF));
      pulse(3);
    end
  endtask

  task automatic final_commit(input logic [15:0] code, input bit ok, input int exp_tries);
    enter(code, 3);
    dial(int'(code[3:0]));
    @(negedge clk); bC = 1'b1;
    @(posedge clk); #1;
    check("check_bus", entry_bus, code);
    check("check_cnt", entry_cnt, 4);
    check("check_still_locked", unlocked, 0);
    @(negedge clk); bC = 1'b0;
    @(posedge clk); #1;
    check("open_after_k1", unlocked, ok);
    if (ok) check("tries_on_open", tries, 0);
    else begin
      @(posedge clk); #1;
      check("tries_after_k2", tries, exp_tries);
      check("lockout_after_k2", lockout, exp_tries == MAXT);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [15:0] rc;

    repeat (3) @(negedge clk);
    bD = 1'b0;
    @(posedge clk); #1;
    check("rst_cur", cur_val, 0);
    check("rst_cnt", entry_cnt, 0);
    check("rst_bus", entry_bus, 0);
    check("rst_flags", {unlocked, prog_mode, lockout}, 0);
    check("rst_tries", tries, 0);

    // Cursor wrap and held button
    pulse(1); check("wrap_down", cur_val, 4'hF);
    pulse(2); check("wrap_up", cur_val, 4'h0);
    @(negedge clk); bL = 1'b1;
    repeat (10) @(negedge clk);
    bL = 1'b0;
    check("hold_once", cur_val, 4'hF);

    // Button held through reset produces no edge afterwards
    @(negedge clk); bR = 1'b1; bD = 1'b1;
    @(negedge clk); bD = 1'b0;
    repeat (3) @(negedge clk);
    bR = 1'b0;
    check("held_thru_reset", cur_val, 4'h0);

    // Unlock with the default code
    final_commit(16'hFACE, 1'b1, 0);
    pulse(3);
    check("relock", unlocked, 0);

    // Three failures into lockout
    final_commit(16'hCACA, 1'b0, 1);
    final_commit(16'hCACA, 1'b0, 2);
    final_commit(16'hCACA, 1'b0, 3);
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      bL = 1'($urandom_range(0, 1)); bR = 1'($urandom_range(0, 1)); bC = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (!lockout) break;
      cnt++;
    end
    check("lockout_len", cnt, LC);
    check("lockout_cur_kept", cur_val, 4'hA);
    check("lockout_cnt_kept", entry_cnt, 0);
    check("lockout_tries_clr", tries, 0);
    @(negedge clk); bL = 1'b0; bR = 1'b0; bC = 1'b0;

    // Reprogram to 1234
    final_commit(16'hFACE, 1'b1, 0);
    pulse(0);
    check("prog_enter", prog_mode, 1);
    enter(16'h1234, 4);
    check("prog_done", {prog_mode, unlocked}, 0);
    final_commit(16'hFACE, 1'b0, 1);
    final_commit(16'h1234, 1'b1, 0);
    pulse(3);
    pulse(4);
    final_commit(16'hFACE, 1'b1, 0);

    // Abort programming, then clear entry
    pulse(0);
    enter(16'h9900, 2);
    check("prog_partial", entry_cnt, 2);
    pulse(0);
    check("abort_open", {unlocked, prog_mode}, 2'b10);
    check("abort_cnt", entry_cnt, 0);
    pulse(3);
    enter(16'hFACE, 2);
    check("clear_pre", entry_cnt, 2);
    pulse(0);
    check("clear_cnt", entry_cnt, 0);
    final_commit(16'hFACE, 1'b1, 0);
    pulse(3);

    // Reset mid-entry
    enter(16'hFACE, 3);
    pulse(4);
    check("midrst_cur", cur_val, 0);
    check("midrst_cnt", entry_cnt, 0);
    check("midrst_bus", entry_bus, 0);
    final_commit(16'hFACE, 1'b1, 0);
    pulse(3);

    // Random codes: program, one near miss, then the right code
    repeat (4) begin
      rc = 16'($urandom);
      pulse(4);
      final_commit(16'hFACE, 1'b1, 0);
      pulse(0);
      enter(rc, 4);
      final_commit(rc ^ 16'h0001, 1'b0, 1);
      final_commit(rc, 1'b1, 0);
      pulse(3);
    end

    // Random button levels with occasional reset
    repeat (3000) begin
      @(negedge clk);
      bU = ($urandom_range(0, 3) == 0);
      bL = ($urandom_range(0, 2) == 0);
      bR = ($urandom_range(0, 2) == 0);
      bC = ($urandom_range(0, 2) == 0);
      bD = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    {bU, bL, bR, bC, bD} = 5'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
